alu_exec_ctrl: RTL and testbench

Execution controller that sequences the 16-bit combinational ALU for the CPU core. It accepts one instruction word per valid/ready handshake and decodes it. It reads operands from the register file, drives the ALU, registers the result and writes it back. It also maintains the processor status register (PSR). Multi-bit immediate shifts are executed as repeated single-bit ALU passes.

---
 rtl/alu_exec_ctrl_if.sv | 51 +++++
 rtl/alu_exec_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_alu_exec_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_ctrl_if.sv
// Signal bundle between the execution controller and its environment:
// instruction handshake, register-file ports, ALU controls/results and status.
interface alu_exec_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;

    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;

    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic        alu_imm_mode;
    logic        alu_carry_in;
    logic        alu_update_flags;
    logic [15:0] alu_result;
    logic        alu_c;
    logic        alu_l;
    logic        alu_f;
    logic        alu_z;
    logic        alu_n;

    logic [4:0]  psr;
    logic        busy;
    logic        done;
    logic        illegal;

    // Controller side
    modport master (
        input  instr_valid, instr, rf_rdata_a, rf_rdata_b,
               alu_result, alu_c, alu_l, alu_f, alu_z, alu_n,
        output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_op, alu_imm_mode, alu_carry_in, alu_update_flags,
               psr, busy, done, illegal
    );

    // Environment side: instruction source, register file and ALU
    modport slave (
        output instr_valid, instr, rf_rdata_a, rf_rdata_b,
               alu_result, alu_c, alu_l, alu_f, alu_z, alu_n,
        input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               alu_a, alu_b, alu_op, alu_imm_mode, alu_carry_in, alu_update_flags,
               psr, busy, done, illegal
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execution controller for the 16-bit combinational ALU: accepts one
// instruction per handshake, reads operands, drives the ALU, writes the
// registered result back and maintains the PSR {C,L,F,Z,N}. Immediate
// shifts run as repeated single-bit LSH passes through the ALU.
module alu_exec_ctrl (
    input  logic            clk,
    input  logic            reset,
    alu_exec_ctrl_if.master bus
);
    localparam logic [3:0] OP_AND    = 4'b0001;
    localparam logic [3:0] OP_OR     = 4'b0010;
    localparam logic [3:0] OP_XOR    = 4'b0011;
    localparam logic [3:0] OP_LSH    = 4'b0100;
    localparam logic [3:0] OP_ADD    = 4'b0101;
    localparam logic [3:0] OP_SUB    = 4'b1001;
    localparam logic [3:0] OP_CMP    = 4'b1011;
    localparam logic [3:0] OP_MOV    = 4'b1101;
    localparam logic [3:0] OP_LUI    = 4'b1111;
    localparam logic [3:0] OPC_RTYPE = 4'b0000;
    localparam logic [3:0] OPC_LSHI  = 4'b1000;

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, WB} state_t;

    state_t      state;
    logic [15:0] ir;        // latched instruction word
    logic        ir_bad;    // latched instruction is undecodable
    logic [15:0] res;       // registered result, doubles as shift working register
    logic        flg_c, flg_l, flg_f, flg_z, flg_n;
    logic [3:0]  cnt;       // remaining shift passes
    logic [4:0]  psr_q;
    logic        done_q, ill_q, we_q;

    logic        in_legal;
    logic        is_rtype, is_lshi, cnt_zero;
    logic [3:0]  dec_op;
    logic        op_flags;
    logic [15:0] shift_b;

    logic [15:0] drv_a, drv_b;
    logic [3:0]  drv_op;
    logic        drv_imm, drv_uf;

    function automatic logic is_legal(input logic [15:0] w);
        logic ok;
        ok = 1'b0;
        case (w[15:12])
            OPC_RTYPE: begin
                case (w[7:4])
                    OP_AND, OP_OR, OP_XOR, OP_LSH,
                    OP_ADD, OP_SUB, OP_CMP, OP_MOV: ok = 1'b1;
                    default:                        ok = 1'b0;
                endcase
            end
            OPC_LSHI: ok = 1'b1;
            OP_AND, OP_OR, OP_XOR, OP_ADD,
            OP_SUB, OP_CMP, OP_MOV, OP_LUI: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Decode of the incoming word (legality) and of the latched word (fields)
    always_comb begin
        in_legal = is_legal(bus.instr);
        is_rtype = (ir[15:12] == OPC_RTYPE);
        is_lshi  = (ir[15:12] == OPC_LSHI);
        cnt_zero = (ir[3:0] == 4'd0);
        if (is_lshi)
            dec_op = OP_LSH;
        else if (is_rtype)
            dec_op = ir[7:4];
        else
            dec_op = ir[15:12];
        op_flags = !is_lshi && ((dec_op == OP_ADD) || (dec_op == OP_SUB) || (dec_op == OP_CMP));
        // bit 4 selects direction: a set sign bit in operand B means shift right
        shift_b  = ir[4] ? 16'h8000 : 16'h0001;
    end

    // ALU operand/control steering; everything idles at zero outside EXEC/SHIFT
    always_comb begin
        drv_a   = 16'h0000;
        drv_b   = 16'h0000;
        drv_op  = 4'b0000;
        drv_imm = 1'b0;
        drv_uf  = 1'b0;
        case (state)
            EXEC: begin
                if (!ir_bad) begin
                    drv_a  = bus.rf_rdata_a;
                    drv_op = dec_op;
                    if (is_lshi) begin
                        drv_b = shift_b;
                    end else if (is_rtype) begin
                        drv_b = bus.rf_rdata_b;
                    end else begin
                        drv_b   = {8'h00, ir[7:0]};
                        drv_imm = 1'b1;
                    end
                    drv_uf = op_flags;
                end
            end
            SHIFT: begin
                drv_a  = res;
                drv_b  = shift_b;
                drv_op = OP_LSH;
            end
            default: ;
        endcase
    end

    // Controller FSM with registered result, flags, PSR and output pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ir     <= 16'h0000;
            ir_bad <= 1'b0;
            res    <= 16'h0000;
            flg_c  <= 1'b0;
            flg_l  <= 1'b0;
            flg_f  <= 1'b0;
            flg_z  <= 1'b0;
            flg_n  <= 1'b0;
            cnt    <= 4'd0;
            psr_q  <= 5'd0;
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            we_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        ir     <= bus.instr;
                        ir_bad <= !in_legal;
                        ill_q  <= !in_legal;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (ir_bad) begin
                        // dropped: no result, no write, no PSR change
                        state <= IDLE;
                    end else begin
                        res   <= bus.alu_result;
                        flg_c <= bus.alu_c;
                        flg_l <= bus.alu_l;
                        flg_f <= bus.alu_f;
                        flg_z <= bus.alu_z;
                        flg_n <= bus.alu_n;
                        if (is_lshi) begin
                            cnt <= ir[3:0] - 4'd1;
                            if (cnt_zero) begin
                                state  <= WB;
                                done_q <= 1'b1;
                            end else if (ir[3:0] == 4'd1) begin
                                state  <= WB;
                                done_q <= 1'b1;
                                we_q   <= 1'b1;
                            end else begin
                                state <= SHIFT;
                            end
                        end else begin
                            state  <= WB;
                            done_q <= 1'b1;
                            we_q   <= (dec_op != OP_CMP);
                        end
                    end
                end
                SHIFT: begin
                    res <= bus.alu_result;
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state  <= WB;
                        done_q <= 1'b1;
                        we_q   <= 1'b1;
                    end
                end
                WB: begin
                    if (!is_lshi && ((dec_op == OP_ADD) || (dec_op == OP_SUB))) begin
                        psr_q[4] <= flg_c;
                        psr_q[2] <= flg_f;
                        psr_q[1] <= flg_z;
                    end else if (!is_lshi && (dec_op == OP_CMP)) begin
                        psr_q[3] <= flg_l;
                        psr_q[1] <= flg_z;
                        psr_q[0] <= flg_n;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready      = (state == IDLE) && !reset;
    assign bus.busy             = (state != IDLE);
    assign bus.done             = done_q;
    assign bus.illegal          = ill_q;
    assign bus.rf_we            = we_q;
    assign bus.rf_waddr         = ir[11:8];
    assign bus.rf_wdata         = res;
    assign bus.rf_raddr_a       = ir[11:8];
    assign bus.rf_raddr_b       = ir[3:0];
    assign bus.psr              = psr_q;
    assign bus.alu_carry_in     = psr_q[4];
    assign bus.alu_a            = drv_a;
    assign bus.alu_b            = drv_b;
    assign bus.alu_op           = drv_op;
    assign bus.alu_imm_mode     = drv_imm;
    assign bus.alu_update_flags = drv_uf;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: register-file and ALU models, a table of
// instruction vectors checked through an expectation queue, plus sequences
// for reset during a long shift and back-to-back issue.
module tb_alu_exec_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_exec_ctrl_if bus();
    alu_exec_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    endtask

    // register file model
    logic [15:0] rf [16];
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [15:0] pre_data;
    assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
    assign bus.rf_rdata_b = rf[bus.rf_raddr_b];
    always @(posedge clk) begin
        if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
        else if (pre_we) rf[pre_addr] <= pre_data;
    end

    // ALU model: C = carry (ADD) / borrow (SUB); CMP sets L unsigned-less, N signed-less
    logic [15:0] m_r;
    logic [16:0] m_s;
    logic        m_c, m_l, m_f, m_n;
    always_comb begin
        m_r = 16'h0; m_s = 17'h0; m_c = 1'b0; m_l = 1'b0; m_f = 1'b0; m_n = 1'b0;
        case (bus.alu_op)
            4'b0001: m_r = bus.alu_a & bus.alu_b;
            4'b0010: m_r = bus.alu_a | bus.alu_b;
            4'b0011: m_r = bus.alu_a ^ bus.alu_b;
            4'b0100: m_r = bus.alu_b[15] ? (bus.alu_a >> 1) : (bus.alu_a << 1);
            4'b0101: begin
                m_s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                m_r = m_s[15:0];
                m_c = m_s[16];
                m_f = (bus.alu_a[15] == bus.alu_b[15]) && (m_r[15] != bus.alu_a[15]);
            end
            4'b1001: begin
                m_r = bus.alu_a - bus.alu_b;
                m_c = (bus.alu_a < bus.alu_b);
                m_f = (bus.alu_a[15] != bus.alu_b[15]) && (m_r[15] != bus.alu_a[15]);
            end
            4'b1011: begin
                m_r = bus.alu_a - bus.alu_b;
                m_l = (bus.alu_a < bus.alu_b);
                m_n = ($signed(bus.alu_a) < $signed(bus.alu_b));
            end
            4'b1101: m_r = bus.alu_b;
            4'b1111: m_r = {bus.alu_b[7:0], bus.alu_a[7:0]};
            default: m_r = 16'h0;
        endcase
    end
    assign bus.alu_result = m_r;
    assign bus.alu_c = m_c;
    assign bus.alu_l = m_l;
    assign bus.alu_f = m_f;
    assign bus.alu_z = (m_r == 16'h0);
    assign bus.alu_n = m_n;

    typedef struct {
        int          id;
        logic        ill;
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [15:0] instr;
        logic [15:0] a_val;   // preloaded into Rdest
        logic [15:0] b_val;   // preloaded into instr[3:0] first
        logic        ill;
        logic        we;
        logic [15:0] wdata;
        int          lat;     // cycles from accept to done/illegal
        logic [4:0]  psr;     // PSR after the instruction retires
    } vec_t;
    vec_t vecs[16];

    // retirement monitor: latency tracking and scoreboard compare
    int lat;
    bit trk = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            trk = 1'b0;
        end else begin
            if (trk) lat++;
            if (bus.instr_valid && bus.instr_ready) begin lat = 0; trk = 1'b1; end
            if (bus.rf_we && !bus.done) chk("we_without_done", 32'(bus.rf_we), 32'd0);
            if (bus.done || bus.illegal) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 32'({bus.done, bus.illegal}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("t%0d_illegal", e.id), 32'(bus.illegal), 32'(e.ill));
                    chk($sformatf("t%0d_done", e.id), 32'(bus.done), 32'(!e.ill));
                    chk($sformatf("t%0d_we", e.id), 32'(bus.rf_we), 32'(e.we));
                    if (e.we) begin
                        chk($sformatf("t%0d_waddr", e.id), 32'(bus.rf_waddr), 32'(e.waddr));
                        chk($sformatf("t%0d_wdata", e.id), 32'(bus.rf_wdata), 32'(e.wdata));
                    end
                    chk($sformatf("t%0d_latency", e.id), 32'(lat), 32'(e.lat));
                end
            end
        end
    end

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input bit push, input exp_t e, output int waits);
        bus.instr_valid = 1'b1;
        bus.instr = w;
        waits = 0;
        while (!bus.instr_ready && waits < 50) begin @(posedge clk); #1; waits++; end
        if (!bus.instr_ready) chk("accept_timeout", 32'(bus.instr_ready), 32'd1);
        else if (push) sb.push_back(e);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin @(posedge clk); #1; n++; end
        if (sb.size() != 0) begin
            chk("retire_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_vec(input int i);
        exp_t e;
        int   w;
        preload(vecs[i].instr[3:0], vecs[i].b_val);
        preload(vecs[i].instr[11:8], vecs[i].a_val);
        e = '{i, vecs[i].ill, vecs[i].we, vecs[i].instr[11:8], vecs[i].wdata, vecs[i].lat};
        send(vecs[i].instr, 1'b1, e, w);
        wait_idle();
        chk($sformatf("v%0d_psr", i), 32'(bus.psr), 32'(vecs[i].psr));
        chk($sformatf("v%0d_ready", i), 32'(bus.instr_ready), 32'd1);
        chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d_carry_in", i), 32'(bus.alu_carry_in), 32'(vecs[i].psr[4]));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t ea, eb;
        int   w;
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = 16'h0;
        pre_we = 1'b0; pre_addr = 4'h0; pre_data = 16'h0;

        //           instr     a_val     b_val     ill   we    wdata     lat psr {C,L,F,Z,N}
        vecs[0]  = '{16'h5101, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 2,  5'b00100};
        vecs[1]  = '{16'h0293, 16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 2,  5'b00010};
        vecs[2]  = '{16'h5701, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 2,  5'b10010};
        vecs[3]  = '{16'h04B5, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 2,  5'b11000};
        vecs[4]  = '{16'h8604, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h0010, 5,  5'b11000};
        vecs[5]  = '{16'h8610, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 2,  5'b11000};
        vecs[6]  = '{16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1,  5'b11000};
        vecs[7]  = '{16'h4123, 16'h00AA, 16'h0055, 1'b1, 1'b0, 16'h0000, 1,  5'b11000};
        vecs[8]  = '{16'h38F0, 16'h0FF0, 16'h0000, 1'b0, 1'b1, 16'h0F00, 2,  5'b11000};
        vecs[9]  = '{16'h091A, 16'hF0F0, 16'hFF00, 1'b0, 1'b1, 16'hF000, 2,  5'b11000};
        vecs[10] = '{16'h8B11, 16'h8000, 16'h0000, 1'b0, 1'b1, 16'h4000, 2,  5'b11000};
        vecs[11] = '{16'h0C2C, 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h1234, 2,  5'b11000};
        vecs[12] = '{16'hDD5A, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 16'h005A, 2,  5'b11000};
        vecs[13] = '{16'h9E10, 16'h0020, 16'h0000, 1'b0, 1'b1, 16'h0010, 2,  5'b01000};
        vecs[14] = '{16'h01F2, 16'h1111, 16'h2222, 1'b1, 1'b0, 16'h0000, 1,  5'b01000};
        vecs[15] = '{16'h830F, 16'h0001, 16'h0000, 1'b0, 1'b1, 16'h8000, 16, 5'b01000};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_we", 32'(bus.rf_we), 32'd0);
        chk("rst_psr", 32'(bus.psr), 32'd0);
        chk("rst_ready", 32'(bus.instr_ready), 32'd0);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) run_vec(i);

        // reset in the middle of a count-15 shift
        preload(4'hF, 16'h0000);
        preload(4'h3, 16'h0001);
        ea = '{100, 1'b0, 1'b1, 4'h3, 16'h8000, 16};
        send(16'h830F, 1'b0, ea, w);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_we", 32'(bus.rf_we), 32'd0);
        chk("abort_psr", 32'(bus.psr), 32'd0);
        chk("abort_ready", 32'(bus.instr_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_we_held", 32'(bus.rf_we), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_rel_ready", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        chk("abort_no_write", 32'(rf[3]), 32'h0001);
        run_vec(0);

        // back-to-back: second instruction held until the controller is idle
        preload(4'h1, 16'h0010);
        preload(4'h2, 16'h00F0);
        ea = '{200, 1'b0, 1'b1, 4'h1, 16'h0011, 2};
        eb = '{201, 1'b0, 1'b1, 4'h2, 16'h00FF, 2};
        send(16'h5101, 1'b1, ea, w);
        send(16'h220F, 1'b1, eb, w);
        chk("b2b_stall", 32'(w), 32'd2);
        wait_idle();
        chk("b2b_psr", 32'(bus.psr), 32'd0);
        chk("b2b_r1", 32'(rf[1]), 32'h0011);
        chk("b2b_r2", 32'(rf[2]), 32'h00FF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
